// File: rtl/sdm_bitstream_gen.sv
// -----------------------------------------------------------------------------
// sdm_bitstream_gen
//   Second-order 1-bit delta-sigma modulator. 16-bit signed PCM samples are
//   queued in a small FIFO. Each sample is held for OSR output bits. Frame
//   marks the first bit of every sample frame.
//
// Parameters
//   OSR         bits per PCM sample (power of 2, 4..1024)
//   FIFO_DEPTH  PCM FIFO entries (power of 2, >= 2)
//   IW          signed integrator width
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous, active-high
//   Din       in   signed PCM sample
//   DinPush   in   write Din into the FIFO this cycle
//   DinFull   out  FIFO full (registered)
//   Enable    in   run request
//   BitOut    out  modulator bit, 1 = +full-scale (registered)
//   Frame     out  1-cycle pulse on the first bit of each frame (registered)
//   Underrun  out  sticky: frame boundary reached with the FIFO empty
//   Overflow  out  sticky: push dropped because the FIFO was full
//   ClrErr    in   clears Underrun/Overflow; a set in the same cycle wins
//
// Build option
//   SDM_DITHER_EN  when defined, a 16-bit LFSR adds +/-1 dither into the
//                  second integrator sum. The port list is the same either way.
// -----------------------------------------------------------------------------
module sdm_bitstream_gen #(
  parameter int OSR        = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int IW         = 24
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Din,
  input  logic        DinPush,
  output logic        DinFull,
  input  logic        Enable,
  output logic        BitOut,
  output logic        Frame,
  output logic        Underrun,
  output logic        Overflow,
  input  logic        ClrErr
);

  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = IW + 2;  // room for a three-term signed sum without wrap

  localparam logic [CW-1:0]        LAST    = CW'(OSR - 1);
  localparam logic [AW:0]          FULL_N  = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [SW-1:0] SAT_HI  = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO  = -SAT_HI;
  localparam logic signed [SW-1:0] FB_POS  = {{(SW-16){1'b0}}, 16'h7FFF};
  localparam logic signed [SW-1:0] FB_NEG  = {{(SW-16){1'b1}}, 16'h8000};

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt_w;
  logic signed [IW-1:0]   i1, i2;
  logic [15:0]            x;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt, fcnt_nxt;
  logic          fifo_empty;
  logic          pop, push_ok, ov_set, under_set;
  logic          run_last, start_prime, start_run;

  assign fifo_empty  = (fcnt == '0);
  assign run_last    = (state == RUN) && (cnt_w == LAST);
  assign start_prime = (state == PRIME) && Enable && !fifo_empty;
  // Frame boundary that continues running (Enable low ends the run instead).
  assign start_run   = run_last && Enable;
  assign pop         = (start_prime || start_run) && !fifo_empty;
  assign under_set   = start_run && fifo_empty;
  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign push_ok     = DinPush && (!DinFull || pop);
  assign ov_set      = DinPush && DinFull && !pop;

  always_comb begin
    fcnt_nxt = fcnt;
    case ({push_ok, pop})
      2'b10:   fcnt_nxt = fcnt + 1'b1;
      2'b01:   fcnt_nxt = fcnt - 1'b1;
      default: fcnt_nxt = fcnt;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fcnt    <= '0;
      DinFull <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fcnt    <= fcnt_nxt;
      DinFull <= (fcnt_nxt == FULL_N);
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= Din;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Underrun <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Underrun <= under_set | (Underrun & ~ClrErr);
      Overflow <= ov_set    | (Overflow & ~ClrErr);
    end
  end

  // ---------------------------------------------------------------------------
  // Modulator loop
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] fb, xs, i1e, i2e, s1, s2, i1ne;
  logic signed [IW-1:0] i1n, i2n;
  logic                 bit_n;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[IW-1:0];
    else if (v < SAT_LO) return SAT_LO[IW-1:0];
    else                 return v[IW-1:0];
  endfunction

`ifdef SDM_DITHER_EN
  logic [15:0]          lfsr;
  logic                 lfsr_fb;
  logic signed [SW-1:0] dith;
  // Taps 16,14,13,11 in right-shift Fibonacci form.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign dith    = lfsr[0] ? {{(SW-1){1'b0}}, 1'b1} : {SW{1'b1}};
`endif

  always_comb begin
    fb   = BitOut ? FB_POS : FB_NEG;
    xs   = {{(SW-16){x[15]}}, x};
    i1e  = {{2{i1[IW-1]}}, i1};
    i2e  = {{2{i2[IW-1]}}, i2};
    s1   = i1e + xs - fb;
    i1n  = sat(s1);
    i1ne = {{2{i1n[IW-1]}}, i1n};
`ifdef SDM_DITHER_EN
    s2   = i2e + i1ne - fb + dith;
`else
    s2   = i2e + i1ne - fb;
`endif
    i2n   = sat(s2);
    bit_n = ~i2n[IW-1];
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered BitOut/Frame
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt_w  <= '0;
      i1     <= '0;
      i2     <= '0;
      x      <= '0;
      BitOut <= 1'b0;
      Frame  <= 1'b0;
`ifdef SDM_DITHER_EN
      lfsr   <= 16'hACE1;
`endif
    end else begin
      Frame <= 1'b0;
      case (state)
        IDLE: begin
          // Mid-scale idle pattern: plain toggle, integrators parked at zero.
          BitOut <= ~BitOut;
          cnt_w  <= '0;
          i1     <= '0;
          i2     <= '0;
`ifdef SDM_DITHER_EN
          lfsr   <= 16'hACE1;
`endif
          if (Enable) state <= PRIME;
        end
        PRIME: begin
          if (!Enable) begin
            BitOut <= ~BitOut;
            state  <= IDLE;
          end else if (!fifo_empty) begin
            // First frame bit comes from zeroed integrators, hence 1.
            BitOut <= 1'b1;
            Frame  <= 1'b1;
            cnt_w  <= '0;
            x      <= mem[rd_ptr];
            state  <= RUN;
          end else begin
            BitOut <= ~BitOut;
          end
        end
        RUN: begin
          if (run_last && !Enable) begin
            // Frame fully emitted; leave without starting another.
            BitOut <= ~BitOut;
            cnt_w  <= '0;
            i1     <= '0;
            i2     <= '0;
            state  <= IDLE;
          end else begin
            i1     <= i1n;
            i2     <= i2n;
            BitOut <= bit_n;
            cnt_w  <= cnt_w + 1'b1;
`ifdef SDM_DITHER_EN
            lfsr   <= {lfsr_fb, lfsr[15:1]};
`endif
            if (run_last) begin
              Frame <= 1'b1;
              // On underrun x simply keeps the previous sample.
              if (!fifo_empty) x <= mem[rd_ptr];
            end
          end
        end
        default: begin
          state  <= IDLE;
          BitOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdm_bitstream_gen.sv
// -----------------------------------------------------------------------------
// tb_sdm_bitstream_gen
//   Directed bench for sdm_bitstream_gen (OSR=256, FIFO_DEPTH=4, IW=24):
//   reset values, idle toggling, FIFO full/overflow/clear, exact first bits
//   of a zero-input frame, frame period, underrun, density at 0 / -0.5 / +0.5 /
//   +FS, Enable drop mid-frame and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_sdm_bitstream_gen;

  localparam int OSR = 256;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Din;
  logic        DinPush;
  logic        DinFull;
  logic        Enable;
  logic        BitOut;
  logic        Frame;
  logic        Underrun;
  logic        Overflow;
  logic        ClrErr;

  int nchk = 0;
  int nerr = 0;

  sdm_bitstream_gen #(.OSR(OSR), .FIFO_DEPTH(4), .IW(24)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Din     (Din),
    .DinPush (DinPush),
    .DinFull (DinFull),
    .Enable  (Enable),
    .BitOut  (BitOut),
    .Frame   (Frame),
    .Underrun(Underrun),
    .Overflow(Overflow),
    .ClrErr  (ClrErr)
  );

  always #5 Clock = ~Clock;

  // Compare got against exp within +/-tol.
  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    nchk++;
    if (got < exp - tol || got > exp + tol) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // One clock: drive, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic [15:0] val, input bit feed);
    Din     = val;
    DinPush = feed && !DinFull;
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_frame(input logic [15:0] val, input bit feed);
    int n;
    n = 0;
    while (!Frame && n < 12) begin
      cyc(val, feed);
      n++;
    end
    chk("frame_start", Frame, 1);
  endtask

  // Called on a Frame cycle; returns ones and first 5 bits, ends on next Frame.
  task automatic one_frame(input logic [15:0] val, input bit feed,
                           output int ones, output logic [4:0] head);
    int stray;
    ones  = 0;
    stray = 0;
    head  = '0;
    for (int k = 0; k < OSR; k++) begin
      if (k > 0 && Frame) stray++;
      ones += int'(BitOut);
      if (k < 5) head[k] = BitOut;
      cyc(val, feed);
    end
    chk("stray_frame", stray, 0);
    chk("frame_period", Frame, 1);
  endtask

  initial begin
    int          ones;
    logic [4:0]  head;
    int          notog;
    logic        prev;

    Reset = 1'b1; Din = '0; DinPush = 0; Enable = 0; ClrErr = 0;
    #22;
    chk("rst_bitout",   BitOut,   0);
    chk("rst_frame",    Frame,    0);
    chk("rst_dinfull",  DinFull,  0);
    chk("rst_underrun", Underrun, 0);
    chk("rst_overflow", Overflow, 0);
    Reset = 1'b0;

    // Idle: toggling from 0, so first edge after release gives 1.
    for (int k = 0; k < 6; k++) begin
      cyc(16'h0000, 0);
      chk("idle_toggle", BitOut, (k % 2 == 0) ? 1 : 0);
      chk("idle_noframe", Frame, 0);
    end

    // FIFO fill with Enable low.
    for (int k = 0; k < 4; k++) begin
      cyc(16'h0000, 1);
      chk("fill_full", DinFull, (k == 3) ? 1 : 0);
    end
    Din = 16'h1234; DinPush = 1; @(posedge Clock); #1;
    chk("ovf_set", Overflow, 1);
    chk("ovf_full", DinFull, 1);
    ClrErr = 1; @(posedge Clock); #1;             // push still high: set wins
    chk("ovf_setwins", Overflow, 1);
    DinPush = 0; @(posedge Clock); #1;
    chk("ovf_clr", Overflow, 0);
    ClrErr = 0;

    // Zero input, 4 samples queued, no further feeding.
    Enable = 1;
    wait_frame(16'h0000, 0);
    for (int f = 1; f <= 6; f++) begin
      one_frame(16'h0000, 0, ones, head);
`ifndef SDM_DITHER_EN
      if (f == 1) chk("zero_head", head, 5'b11001);
`endif
      if (f >= 3) chk("zero_density", ones, 128, 2);
      chk("underrun", Underrun, (f >= 4) ? 1 : 0);
    end

    // -0.5 FS
    for (int f = 1; f <= 6; f++) begin
      one_frame(16'hC000, 1, ones, head);
      if (f >= 5) chk("neg_half_density", ones, 64, 2);
    end
    // +0.5 FS (FIFO holds four 0xC000 entries to flush first)
    for (int f = 1; f <= 9; f++) begin
      one_frame(16'h4000, 1, ones, head);
      if (f >= 8) chk("pos_half_density", ones, 192, 2);
    end

    // Drop Enable at count 100: 156 more run bits, then idle toggling.
    ones = 0;
    prev = 1'b0;
    for (int k = 0; k < OSR; k++) begin
      if (k == 100) Enable = 0;
      if (k >= 100) ones += int'(BitOut);
      if (k == OSR - 1) prev = BitOut;
      cyc(16'h4000, 0);
    end
    chk("drop_tail_density", ones, 117, 3);
    notog = 0;
    for (int k = 0; k < 16; k++) begin
      if (Frame) notog++;
      if (BitOut == prev) notog++;
      prev = BitOut;
      cyc(16'h4000, 0);
    end
    chk("drop_idle_toggle", notog, 0);

    // Restart, then asynchronous reset at count 37.
    Enable = 1;
    wait_frame(16'h4000, 0);
    for (int k = 1; k < 37; k++) cyc(16'h4000, 1);
    Din = 16'h4000; DinPush = 1; @(posedge Clock); #1;  // count 37, push while full
    DinPush = 0;
    chk("pre_rst_full", DinFull, 1);
    chk("pre_rst_ovf", Overflow, 1);
    chk("pre_rst_under", Underrun, 1);
    #2 Reset = 1;
    #1;
    chk("mid_rst_bitout", BitOut, 0);
    chk("mid_rst_frame", Frame, 0);
    chk("mid_rst_full", DinFull, 0);
    chk("mid_rst_under", Underrun, 0);
    chk("mid_rst_ovf", Overflow, 0);
    @(posedge Clock); #1;
    chk("mid_rst_hold", BitOut, 0);
    Reset = 0;

    // Near +FS.
    wait_frame(16'h7FFF, 1);
    for (int f = 1; f <= 4; f++) begin
      one_frame(16'h7FFF, 1, ones, head);
      if (f >= 3) chk("max_density", ones, 255, 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
